// File: rtl/sr_event_capture_pkg.sv
// Shared types for the SR-latch event capture stage: filter FSM states and
// edge-type codes carried in the MSB of each event record.
package sr_event_capture_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_PEND = 2'd1,
        HIGH      = 2'd2,
        FALL_PEND = 2'd3
    } filt_state_t;

    localparam logic EV_RISE = 1'b1;
    localparam logic EV_FALL = 1'b0;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for one asynchronous level; only the last stage is
// meant to be consumed. Reset value is chosen per instance.
module sync_chain #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= {STAGES{RST_VAL}};
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sr_event_capture.sv
// Synchronizes and debounces complementary NAND-latch outputs, flags the
// illegal equal state, emits edge pulses, counts rises and buffers edge events.
module sr_event_capture
    import sr_event_capture_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    input  logic             q_nin,
    output logic             state,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             invalid,
    output logic [CNT_W-1:0] rise_count,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [CNT_W:0]   ev_data,
    output logic             overflow
);

    localparam int FCW = $clog2(FILTER_CYCLES + 1);

    logic           sq, sqn, sync_ok;
    filt_state_t    st, st_nxt;
    logic [FCW-1:0] cnt, cnt_nxt, cnt_inc;
    logic           rise_nxt, fall_nxt;
    logic [CNT_W:0] ev_load;

    sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_q (
        .clk(clk), .rst(rst), .d(q_in), .q(sq)
    );

    sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_qn (
        .clk(clk), .rst(rst), .d(q_nin), .q(sqn)
    );

    // The FSM uses the unregistered check so that freezing lines up with the
    // registered invalid flag going high on the same edge.
    assign sync_ok = (sq != sqn);
    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        st_nxt   = st;
        cnt_nxt  = cnt;
        rise_nxt = 1'b0;
        fall_nxt = 1'b0;
        if (!sync_ok) begin
            cnt_nxt = '0;
        end else begin
            unique case (st)
                LOW: if (sq) begin
                    if (FILTER_CYCLES == 1) begin
                        st_nxt   = HIGH;
                        rise_nxt = 1'b1;
                    end else begin
                        st_nxt  = RISE_PEND;
                        cnt_nxt = FCW'(1);
                    end
                end
                RISE_PEND: if (!sq) begin
                    st_nxt  = LOW;
                    cnt_nxt = '0;
                end else if (cnt_inc == FCW'(FILTER_CYCLES)) begin
                    st_nxt   = HIGH;
                    cnt_nxt  = '0;
                    rise_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
                HIGH: if (!sq) begin
                    if (FILTER_CYCLES == 1) begin
                        st_nxt   = LOW;
                        fall_nxt = 1'b1;
                    end else begin
                        st_nxt  = FALL_PEND;
                        cnt_nxt = FCW'(1);
                    end
                end
                FALL_PEND: if (sq) begin
                    st_nxt  = HIGH;
                    cnt_nxt = '0;
                end else if (cnt_inc == FCW'(FILTER_CYCLES)) begin
                    st_nxt   = LOW;
                    cnt_nxt  = '0;
                    fall_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
                default: st_nxt = LOW;
            endcase
        end
    end

    // A rise event carries the post-increment count.
    assign ev_load = rise_nxt ? {EV_RISE, rise_count + 1'b1} : {EV_FALL, rise_count};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= LOW;
            cnt        <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            invalid    <= 1'b0;
            rise_count <= '0;
            ev_valid   <= 1'b0;
            ev_data    <= '0;
            overflow   <= 1'b0;
        end else begin
            st         <= st_nxt;
            cnt        <= cnt_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
            invalid    <= !sync_ok;
            if (rise_nxt) rise_count <= rise_count + 1'b1;
            if (rise_nxt || fall_nxt) begin
                if (!ev_valid || ev_ready) begin
                    ev_valid <= 1'b1;
                    ev_data  <= ev_load;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (ev_ready) begin
                ev_valid <= 1'b0;
            end
        end
    end

    assign state = (st == HIGH) || (st == FALL_PEND);

endmodule
